// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI4-Lite initiator behind a command/response handshake
module axi_lite_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_awaddr,
    output logic                    M_AXI_LITE_awvalid,
    input  logic                    M_AXI_LITE_awready,
    output logic [DATA_WIDTH-1:0]   M_AXI_LITE_wdata,
    output logic [DATA_WIDTH/8-1:0] M_AXI_LITE_wstrb,
    output logic                    M_AXI_LITE_wvalid,
    input  logic                    M_AXI_LITE_wready,
    input  logic [1:0]              M_AXI_LITE_bresp,
    input  logic                    M_AXI_LITE_bvalid,
    output logic                    M_AXI_LITE_bready,
    output logic [ADDR_WIDTH-1:0]   M_AXI_LITE_araddr,
    output logic                    M_AXI_LITE_arvalid,
    input  logic                    M_AXI_LITE_arready,
    input  logic [DATA_WIDTH-1:0]   M_AXI_LITE_rdata,
    input  logic [1:0]              M_AXI_LITE_rresp,
    input  logic                    M_AXI_LITE_rvalid,
    output logic                    M_AXI_LITE_rready
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    // A write leg is finished once its valid is low or handshaking on this edge
    logic aw_done, w_done;
    assign aw_done = !M_AXI_LITE_awvalid || M_AXI_LITE_awready;
    assign w_done  = !M_AXI_LITE_wvalid || M_AXI_LITE_wready;
    assign cmd_ready         = state == IDLE;
    assign rsp_valid         = state == RSP;
    assign M_AXI_LITE_bready = state == WR_RESP;
    assign M_AXI_LITE_rready = state == RD_RESP;
    assign M_AXI_LITE_awaddr = addr;
    assign M_AXI_LITE_araddr = addr;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= IDLE;
            addr               <= '0;
            M_AXI_LITE_wdata   <= '0;
            M_AXI_LITE_wstrb   <= '0;
            M_AXI_LITE_awvalid <= 1'b0;
            M_AXI_LITE_wvalid  <= 1'b0;
            M_AXI_LITE_arvalid <= 1'b0;
            rsp_rdata          <= '0;
            rsp_resp           <= 2'b00;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    addr               <= cmd_addr;
                    M_AXI_LITE_wdata   <= cmd_wdata;
                    M_AXI_LITE_wstrb   <= cmd_wstrb;
                    M_AXI_LITE_awvalid <= cmd_write;
                    M_AXI_LITE_wvalid  <= cmd_write;
                    M_AXI_LITE_arvalid <= !cmd_write;
                    state              <= cmd_write ? WR_REQ : RD_REQ;
                end
                WR_REQ: begin
                    if (M_AXI_LITE_awready) M_AXI_LITE_awvalid <= 1'b0;
                    if (M_AXI_LITE_wready) M_AXI_LITE_wvalid <= 1'b0;
                    if (aw_done && w_done) state <= WR_RESP;
                end
                WR_RESP: if (M_AXI_LITE_bvalid) begin
                    rsp_resp  <= M_AXI_LITE_bresp;
                    rsp_rdata <= '0;
                    state     <= RSP;
                end
                RD_REQ: if (M_AXI_LITE_arready) begin
                    M_AXI_LITE_arvalid <= 1'b0;
                    state              <= RD_RESP;
                end
                RD_RESP: if (M_AXI_LITE_rvalid) begin
                    rsp_rdata <= M_AXI_LITE_rdata;
                    rsp_resp  <= M_AXI_LITE_rresp;
                    state     <= RSP;
                end
                RSP: if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed bench with a stallable AXI4-Lite slave model
module tb_axi_lite_master;
    localparam int AW = 4;
    localparam int DW = 32;
    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          rsp_valid, rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, arvalid, bready, rready;
    logic          awready = 1'b0, wready = 1'b0, arready = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
    logic [DW-1:0] wdata, rdata = '0;
    logic [3:0]    wstrb;
    logic [1:0]    bresp = 2'b00, rresp = 2'b00;

    axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_LITE_awaddr(awaddr), .M_AXI_LITE_awvalid(awvalid), .M_AXI_LITE_awready(awready),
        .M_AXI_LITE_wdata(wdata), .M_AXI_LITE_wstrb(wstrb), .M_AXI_LITE_wvalid(wvalid),
        .M_AXI_LITE_wready(wready),
        .M_AXI_LITE_bresp(bresp), .M_AXI_LITE_bvalid(bvalid), .M_AXI_LITE_bready(bready),
        .M_AXI_LITE_araddr(araddr), .M_AXI_LITE_arvalid(arvalid), .M_AXI_LITE_arready(arready),
        .M_AXI_LITE_rdata(rdata), .M_AXI_LITE_rresp(rresp), .M_AXI_LITE_rvalid(rvalid),
        .M_AXI_LITE_rready(rready)
    );

    int tests = 0, fails = 0;
    int aw_stall = 0, w_stall = 0, ar_stall = 0, b_stall = 0, r_stall = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [1:0]    b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic          r_ovr = 1'b0;
    logic [DW-1:0] r_ovr_data = '0;
    logic [DW-1:0] smem [4];
    logic [DW-1:0] emem [4];
    logic          got_aw = 1'b0, got_w = 1'b0, pend_b = 1'b0, pend_r = 1'b0;
    logic [AW-1:0] cap_aw = '0, cap_ar = '0;
    logic [DW-1:0] cap_w = '0;
    logic [3:0]    cap_s = '0;
    int            n_b = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [3:0] s);
        merge = old;
        for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave bookkeeping: records handshakes seen at each rising edge
    always @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < 4; i++) smem[i] = '0;
            got_aw = 1'b0; got_w = 1'b0; pend_b = 1'b0; pend_r = 1'b0;
        end else begin
            if (bvalid && bready) begin pend_b = 1'b0; n_b++; end
            if (awvalid && awready) begin cap_aw = awaddr; got_aw = 1'b1; end
            if (wvalid && wready) begin cap_w = wdata; cap_s = wstrb; got_w = 1'b1; end
            if (got_aw && got_w) begin
                smem[cap_aw[3:2]] = merge(smem[cap_aw[3:2]], cap_w, cap_s);
                got_aw = 1'b0; got_w = 1'b0; pend_b = 1'b1;
            end
            if (rvalid && rready) pend_r = 1'b0;
            if (arvalid && arready) begin cap_ar = araddr; pend_r = 1'b1; end
        end
    end

    // Slave drive: readies/valids change on the falling edge after the configured stall
    always @(negedge aclk) begin
        if (!aresetn) begin
            awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        end else begin
            awready = awvalid && aw_cnt >= aw_stall;
            aw_cnt  = awvalid ? aw_cnt + (awready ? 0 : 1) : 0;
            wready  = wvalid && w_cnt >= w_stall;
            w_cnt   = wvalid ? w_cnt + (wready ? 0 : 1) : 0;
            arready = arvalid && ar_cnt >= ar_stall;
            ar_cnt  = arvalid ? ar_cnt + (arready ? 0 : 1) : 0;
            if (!pend_b) begin bvalid = 1'b0; b_cnt = 0; end
            else if (!bvalid) begin
                if (b_cnt >= b_stall) begin bvalid = 1'b1; bresp = b_resp_cfg; end
                else b_cnt++;
            end
            if (!pend_r) begin rvalid = 1'b0; r_cnt = 0; end
            else if (!rvalid) begin
                if (r_cnt >= r_stall) begin
                    rvalid = 1'b1; rresp = r_resp_cfg;
                    rdata = r_ovr ? r_ovr_data : smem[cap_ar[3:2]];
                end else r_cnt++;
            end
        end
    end

    // Returns at the falling edge of cycle 1 (the cycle after the accepting edge)
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int k = 0;
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && k < 20) begin @(negedge aclk); k++; end
        check("cmd_accept_bound", k < 20, 1);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int start, output int n);
        n = start;
        while (!rsp_valid && n < 40) begin @(negedge aclk); n++; end
        check("rsp_bound", rsp_valid, 1);
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int n, seen, b0;
        logic w;
        logic [1:0] idx;
        logic [DW-1:0] d;
        logic [3:0] s;
        for (int i = 0; i < 4; i++) emem[i] = '0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check("reset_regs", {rsp_rdata, rsp_resp, awaddr, wdata, wstrb}, 0);

        // Write against an always-ready slave
        issue(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
        check("wr_c1_valids", {awvalid, wvalid}, 2'b11);
        check("wr_c1_awaddr", awaddr, 4'h4);
        check("wr_c1_wdata", wdata, 32'hDEADBEEF);
        check("wr_c1_wstrb", wstrb, 4'hF);
        wait_rsp(1, n);
        check("wr_latency", n, 3);
        check("wr_resp", rsp_resp, 2'b00);
        check("wr_rdata", rsp_rdata, 0);
        consume();
        check("wr_slave_mem", smem[1], 32'hDEADBEEF);
        emem[1] = 32'hDEADBEEF;

        // Skewed write: address channel stalls three cycles
        aw_stall = 3;
        b0 = n_b;
        issue(1'b1, 4'h8, 32'hCAFEF00D, 4'h3);
        check("skew_c1_valids", {awvalid, wvalid}, 2'b11);
        @(negedge aclk);
        check("skew_c2_wvalid", wvalid, 0);
        for (int c = 2; c <= 4; c++) begin
            if (c > 2) @(negedge aclk);
            check("skew_awvalid_held", awvalid, 1);
            check("skew_awaddr_stable", awaddr, 4'h8);
        end
        wait_rsp(4, n);
        check("skew_latency", n, 6);
        check("skew_resp", rsp_resp, 2'b00);
        consume();
        check("skew_one_b", n_b - b0, 1);
        emem[2] = 32'h0000F00D;
        aw_stall = 0;

        // Read with delayed SLVERR response
        r_stall = 2; r_ovr = 1'b1; r_ovr_data = 32'h12345678; r_resp_cfg = 2'b10;
        issue(1'b0, 4'h8, 32'h0, 4'h0);
        check("rd_c1_arvalid", arvalid, 1);
        check("rd_c1_araddr", araddr, 4'h8);
        wait_rsp(1, n);
        check("rderr_latency", n, 5);
        check("rderr_rdata", rsp_rdata, 32'h12345678);
        check("rderr_resp", rsp_resp, 2'b10);
        consume();
        check("rderr_done", rsp_valid, 0);
        r_stall = 0; r_ovr = 1'b0; r_resp_cfg = 2'b00;

        // Response backpressure with the next command already waiting
        issue(1'b0, 4'h4, 32'h0, 4'h0);
        wait_rsp(1, n);
        check("bp_latency", n, 3);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge aclk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", {rsp_rdata, rsp_resp}, {32'hDEADBEEF, 2'b00});
            check("bp_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge aclk);
        rsp_ready = 1'b0;
        check("bp_cmd_ready_after", cmd_ready, 1);
        check("bp_rsp_dropped", rsp_valid, 0);
        @(negedge aclk);
        cmd_valid = 1'b0;
        check("bp_next_araddr", {arvalid, araddr}, {1'b1, 4'h8});
        wait_rsp(1, n);
        check("bp_next_rdata", rsp_rdata, 32'h0000F00D);
        consume();

        // Back-to-back mix with random slave stalls
        for (int i = 0; i < 8; i++) begin
            w = i < 6 ? 1'($urandom_range(0, 1)) : 1'b0;
            idx = 2'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            aw_stall = $urandom_range(0, 2); w_stall = $urandom_range(0, 2);
            b_stall = $urandom_range(0, 2); ar_stall = $urandom_range(0, 2);
            r_stall = $urandom_range(0, 2);
            issue(w, {idx, 2'b00}, d, s);
            wait_rsp(1, n);
            check("mix_resp", rsp_resp, 2'b00);
            if (w) begin
                check("mix_wr_rdata", rsp_rdata, 0);
                emem[idx] = merge(emem[idx], d, s);
            end else check("mix_rd_rdata", rsp_rdata, emem[idx]);
            consume();
        end
        aw_stall = 10; w_stall = 10; b_stall = 0; ar_stall = 0; r_stall = 0;

        // Reset in WR_REQ with awvalid pending
        issue(1'b1, 4'h4, 32'h55AA55AA, 4'hF);
        check("rst_pre_awvalid", awvalid, 1);
        #2 aresetn = 1'b0;
        #1;
        check("rst_async_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check("rst_async_cmd_ready", cmd_ready, 1);
        aw_stall = 0; w_stall = 0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge aclk);
            if (rsp_valid || awvalid || wvalid) seen++;
        end
        check("rst_no_activity", seen, 0);
        check("rst_cmd_ready_after", cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

AXI4-Lite initiator that turns a single-entry command/response interface into AXI4-Lite read and write transactions. It drives the `AXI_LITE` register slaves in the peripheral subsystem from local control logic, for example a sequencer or debug bridge. It has no CPU bus in between. Only one transaction is outstanding at a time.

## Interface
Parameters:
- ADDR_WIDTH, 4, address width; matches the slave register blocks.
- DATA_WIDTH, 32, data width; must be 32 or 64.

Ports:
- aclk  in  1  clock; everything is sampled on the rising edge.
- aresetn  in  1  reset; one clock, reset is asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP returned by the slave.
- M_AXI_LITE_awaddr/awvalid (out), awready (in): write address channel.
- M_AXI_LITE_wdata/wstrb/wvalid (out), wready (in): write data channel.
- M_AXI_LITE_bresp/bvalid (in), bready (out): write response channel.
- M_AXI_LITE_araddr/arvalid (out), arready (in): read address channel.
- M_AXI_LITE_rdata/rresp/rvalid (in), rready (out): read data channel.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1 (combinational on state == IDLE).
  - On cmd_valid, register addr/wdata/wstrb into awaddr/araddr/wdata/wstrb.
  - Go to WR_REQ (cmd_write = 1) or RD_REQ (cmd_write = 0).
  - Set awvalid and wvalid (write) or arvalid (read) on the same edge.
- WR_REQ:
  - awvalid and wvalid are independent registered flags.
  - Each clears on the edge where it handshakes (valid & ready).
  - When both handshakes are done, including on the same edge, go to WR_RESP.
  - Neither valid may drop before its handshake.
  - awaddr, wdata and wstrb stay stable while their valid is high.
- WR_RESP: bready = 1. On bvalid, capture bresp into rsp_resp, set rsp_rdata = 0, go to RSP.
- RD_REQ: arvalid held until arready; on that handshake clear arvalid and go to RD_RESP.
- RD_RESP: rready = 1. On rvalid, capture rdata into rsp_rdata and rresp into rsp_resp, go to RSP.
- RSP:
  - rsp_valid = 1, with rsp_rdata and rsp_resp held stable.
  - On rsp_ready, go to IDLE.
  - A new command is not accepted on the same edge.
- bready and rready are high only in WR_RESP and RD_RESP respectively.
- SLVERR (2'b10) and DECERR (2'b11) pass to rsp_resp unchanged. The FSM does not branch on them.
- Slave responses arriving outside the expected state are not accepted. The slave must not produce them; this is an assertion target.
- Reset (aresetn low, asynchronous):
  - state = IDLE.
  - All AXI valid/ready outputs = 0, rsp_valid = 0.
  - rsp_rdata, rsp_resp, awaddr, araddr, wdata, wstrb = 0.
  - cmd_ready = 1 once reset is applied, since it follows state == IDLE.
  - Reset mid-transaction abandons the transaction; no response is produced.

## Timing
Latency, with an always-ready slave and a zero-wait slave response:
- Write:
  - cycle 0: command accepted.
  - cycle 1: awvalid/wvalid high, both handshake.
  - cycle 2: bready high; bvalid is returned and handshakes.
  - cycle 3: rsp_valid high.
- Read:
  - cycle 1: arvalid handshake.
  - cycle 2: rvalid handshake.
  - cycle 3: rsp_valid high.
- With rsp_ready tied high, cmd_ready returns at cycle 4, giving a throughput of 1 transaction per 4 cycles.
- Each slave stall (awready, wready, arready, bvalid, rvalid low) adds exactly one cycle per stalled cycle.
- No combinational path from any AXI input to any AXI output.
- cmd_ready depends only on state.

## Test plan
- Write, always-ready slave:
  - Stimulus: cmd addr 0x4, wdata 0xDEADBEEF, wstrb 0xF.
  - Required: awaddr 0x4 and wdata 0xDEADBEEF handshake in cycle 1; rsp_valid in cycle 3 with rsp_resp 2'b00 and rsp_rdata 0.
- Skewed write handshakes:
  - Stimulus: awready held low for 3 cycles while wready is high.
  - Required: wvalid drops after 1 cycle; awvalid stays high with stable awaddr until its handshake; exactly one B accepted; rsp_valid 3 cycles later than the unstalled case.
- Read with error:
  - Stimulus: read addr 0x8; slave delays rvalid 2 cycles, then returns rdata 0x12345678 with rresp 2'b10.
  - Required: rsp_rdata 0x12345678, rsp_resp 2'b10, rsp_valid in cycle 5.
- Response backpressure:
  - Stimulus: rsp_ready low for 4 cycles, cmd_valid held high.
  - Required: rsp held stable; cmd_ready stays 0 until the cycle after rsp_ready.
- Back-to-back mix:
  - Stimulus: 8 random reads and writes against a scoreboard slave model.
  - Required: every read returns the last written value, masked per wstrb.
- Reset mid-operation:
  - Stimulus: assert aresetn low while in WR_REQ with awvalid high.
  - Required: all valids and readies go 0 immediately (asynchronously); cmd_ready is 1 after release; no rsp_valid is produced.
